min_sec_counter: RTL and testbench
==================================

// Module: min_sec_counter
// PURPOSE
// - Two-digit BCD seconds and minutes timekeeper; stage directly upstream of the 24-hour BCD counter.
// - Advances on a 1 Hz strobe. Emits a one-cycle hour_tick when 59:59 wraps to 00:00; this tick drives the hour stage.
// - Button-driven set mode edits minutes and seconds. A blink output lets the display flash the field being edited.
// PARAMETERS
// - SEC_WRAP   8'h59       BCD terminal value of seconds; next value wraps to 8'h00
// - MIN_WRAP   8'h59       BCD terminal value of minutes; next value wraps to 8'h00
// - BLINK_DIV  25_000_000  clk cycles per blink half-period in set modes (>=2)
// PORTS
// - clk        in   1  system clock; all state changes on posedge
// - reset      in   1  reset, synchronous, active-low
// - sec_tick   in   1  1 Hz strobe, one clk cycle wide
// - mode_btn   in   1  debounced single-cycle pulse; steps the mode
// - inc_btn    in   1  debounced single-cycle pulse; increments the selected field
// - seconds    out  8  BCD seconds {tens,units}, 00..SEC_WRAP
// - minutes    out  8  BCD minutes {tens,units}, 00..MIN_WRAP
// - hour_tick  out  1  one-cycle pulse on the 59:59->00:00 wrap in RUN
// - set_mode   out  2  2'b00 RUN, 2'b01 SET_MIN, 2'b10 SET_SEC
// - blink      out  1  display enable for the edited field
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - seconds=8'h00, minutes=8'h00, hour_tick=0, set_mode=RUN, blink=1.
//   - Blink counter cleared to 0. Reset overrides every other input.
// - BCD increment:
//   - units 9 -> 0 with tens+1; otherwise units+1.
//   - A field whose value is >= its WRAP compare (incl. illegal nibbles > 9) goes to 8'h00.
// - RUN, on sec_tick:
//   - seconds increments.
//   - On seconds wrap, minutes increments in the same cycle.
//   - On a simultaneous minutes wrap, hour_tick=1 for exactly the next cycle.
//   - Latency: outputs update at the posedge that samples sec_tick; hour_tick is registered in that same edge.
// - hour_tick is 0 in every other cycle. It never asserts from set-mode edits.
// - FSM:
//   - mode_btn steps RUN -> SET_MIN -> SET_SEC -> RUN.
//   - Unused encoding 2'b11 recovers to RUN on the next clk.
// - SET_MIN / SET_SEC:
//   - sec_tick is ignored, so time is frozen.
//   - inc_btn increments only the selected field, wrapping at its WRAP to 00. There is no carry into the other field.
// - In RUN, inc_btn is ignored.
// - Leaving SET_SEC -> RUN resumes counting from the edited value; no field is cleared.
// - Simultaneous events:
//   - mode_btn and inc_btn in the same cycle: mode change wins; inc is discarded.
//   - sec_tick and mode_btn in RUN: the tick is fully processed (including hour_tick), and the state moves to SET_MIN at the same edge.
// - Blink:
//   - In RUN, blink=1 constantly and the counter is held at 0.
//   - On entry to any set state, blink=1 and the counter=0.
//   - The counter counts clk cycles. At BLINK_DIV-1 it resets to 0 and blink toggles.
// - Held-high buttons count as one pulse per clk cycle; debouncing is upstream.
// STRUCTURE
// - Shared package clock_pkg holds:
//   - mode encodings MODE_RUN, MODE_SET_MIN, MODE_SET_SEC;
//   - BCD constants BCD_ZERO=8'h00 and BCD_59=8'h59;
//   - the bcd_inc helper function.
//   The hour stage reuses this package.
// - One sub-module, bcd_mod_counter:
//   - parameter WRAP; ports clk, reset, inc, q[7:0], wrap_out;
//   - wrap_out is a combinational "q>=WRAP && inc".
//   - Instantiated twice, for seconds and minutes.
// - Top level holds the mode FSM, inc steering, the hour_tick register and the blink divider.
// TESTING
// - Reset and count:
//   - Stimulus: reset=0 for 2 clk, then 61 sec_tick pulses.
//   - Expect: minutes=8'h01, seconds=8'h01, hour_tick never 1.
// - Hour wrap:
//   - Stimulus: set time to 59:58, then 2 sec_ticks.
//   - Expect: 59:59, then 00:00. hour_tick=1 in exactly one cycle, the one after the 2nd tick's edge.
// - Set mode:
//   - Stimulus: mode_btn; 3 inc_btn; mode_btn; 2 inc_btn; mode_btn, starting from 00:00.
//   - Expect: 03:02, set_mode back to 00; sec_ticks during edit leave time unchanged.
// - Field wrap in set:
//   - Stimulus: minutes=59 in SET_MIN, then inc_btn.
//   - Expect: minutes=00, seconds unchanged, hour_tick=0.
// - Simultaneous events:
//   - Stimulus 1: mode_btn+inc_btn together in SET_MIN.
//   - Expect: SET_SEC, minutes unchanged.
//   - Stimulus 2: sec_tick+mode_btn at 59:59 in RUN.
//   - Expect: 00:00, hour_tick pulse, set_mode=01.
// - Blink and mid-operation reset:
//   - Stimulus 1: BLINK_DIV=4 in SET_SEC.
//   - Expect: blink toggles every 4 clk.
//   - Stimulus 2: reset=0 mid-edit.
//   - Expect: 00:00, RUN, blink=1.

Source files
------------

// File: rtl/clock_pkg.sv
// ============================================================================
// clock_pkg
// Shared mode encodings, BCD constants and BCD increment helper for the
// clock counter stages.
// Revision: 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam logic [1:0] MODE_RUN     = 2'b00;
    localparam logic [1:0] MODE_SET_MIN = 2'b01;
    localparam logic [1:0] MODE_SET_SEC = 2'b10;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] BCD_59   = 8'h59;

    // Two-digit BCD increment without terminal-value handling.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// ============================================================================
// bcd_mod_counter
// Two-digit BCD counter that returns to 00 after reaching WRAP.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] WRAP = BCD_59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    output logic [7:0] q,
    output logic       wrap_out
);

    logic [7:0] r_q;
    logic       w_at_wrap;

    // Values at or past WRAP (including illegal nibbles) fold back to zero.
    assign w_at_wrap = (r_q >= WRAP);
    assign wrap_out  = w_at_wrap && inc;
    assign q         = r_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= BCD_ZERO;
        end else if (inc) begin
            r_q <= w_at_wrap ? BCD_ZERO : bcd_inc(r_q);
        end
    end

endmodule

`default_nettype wire

// File: rtl/min_sec_counter.sv
// ============================================================================
// min_sec_counter
// BCD minutes/seconds timekeeper with set mode, blink divider and hour tick.
// Revision: 1.0
// ============================================================================
`default_nettype none

module min_sec_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] SEC_WRAP  = BCD_59,
    parameter logic [7:0] MIN_WRAP  = BCD_59,
    parameter int         BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] seconds,
    output logic [7:0] minutes,
    output logic       hour_tick,
    output logic [1:0] set_mode,
    output logic       blink
);

    localparam int c_cnt_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(BLINK_DIV - 1);

    logic [1:0]         r_mode;
    logic [1:0]         w_mode_next;
    logic               r_hour_tick;
    logic               r_blink;
    logic [c_cnt_w-1:0] r_blink_cnt;
    logic               w_run;
    logic               w_edit_inc;
    logic               w_sec_inc;
    logic               w_min_inc;
    logic               w_sec_wrap;
    logic               w_min_wrap;

    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            MODE_RUN:     if (mode_btn) w_mode_next = MODE_SET_MIN;
            MODE_SET_MIN: if (mode_btn) w_mode_next = MODE_SET_SEC;
            MODE_SET_SEC: if (mode_btn) w_mode_next = MODE_RUN;
            default:      w_mode_next = MODE_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode <= MODE_RUN;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // A mode press in the same cycle discards the edit increment.
    assign w_run      = (r_mode == MODE_RUN);
    assign w_edit_inc = inc_btn && !mode_btn;
    assign w_sec_inc  = (w_run && sec_tick) || ((r_mode == MODE_SET_SEC) && w_edit_inc);
    assign w_min_inc  = (w_run && w_sec_wrap) || ((r_mode == MODE_SET_MIN) && w_edit_inc);

    bcd_mod_counter #(
        .WRAP     (SEC_WRAP)
    ) u_sec (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_sec_inc),
        .q        (seconds),
        .wrap_out (w_sec_wrap)
    );

    bcd_mod_counter #(
        .WRAP     (MIN_WRAP)
    ) u_min (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_min_inc),
        .q        (minutes),
        .wrap_out (w_min_wrap)
    );

    // Minutes only wrap through a seconds carry in RUN; edits never tick the hour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hour_tick <= 1'b0;
        end else begin
            r_hour_tick <= w_run && w_min_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if ((w_mode_next != r_mode) || (w_mode_next == MODE_RUN)) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == c_cnt_max) begin
            r_blink     <= ~r_blink;
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign hour_tick = r_hour_tick;
    assign set_mode  = r_mode;
    assign blink     = r_blink;

endmodule

`default_nettype wire

// File: tb/tb_min_sec_counter.sv
// ============================================================================
// tb_min_sec_counter
// Directed vector table plus hand-written sequences for min_sec_counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_min_sec_counter;

    logic       clk;
    logic       reset;
    logic       sec_tick;
    logic       mode_btn;
    logic       inc_btn;
    logic [7:0] seconds;
    logic [7:0] minutes;
    logic       hour_tick;
    logic [1:0] set_mode;
    logic       blink;

    int n_vec;
    int n_bad;

    min_sec_counter #(
        .SEC_WRAP  (8'h59),
        .MIN_WRAP  (8'h59),
        .BLINK_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sec_tick  (sec_tick),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .seconds   (seconds),
        .minutes   (minutes),
        .hour_tick (hour_tick),
        .set_mode  (set_mode),
        .blink     (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       tick;
        logic       mode;
        logic       inc;
        logic [7:0] e_sec;
        logic [7:0] e_min;
        logic       e_ht;
        logic [1:0] e_mode;
        logic       e_blink;
    } vec_t;

    localparam int c_nvec = 20;
    vec_t tbl [c_nvec];

    function automatic vec_t mk(input logic r, input logic t, input logic m, input logic i,
                                input logic [7:0] s, input logic [7:0] mn,
                                input logic h, input logic [1:0] md, input logic b);
        vec_t v;
        v.rst_n = r; v.tick = t; v.mode = m; v.inc = i;
        v.e_sec = s; v.e_min = mn; v.e_ht = h; v.e_mode = md; v.e_blink = b;
        return v;
    endfunction

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic r, input logic t, input logic m, input logic i);
        reset = r; sec_tick = t; mode_btn = m; inc_btn = i;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_time(input string name, input logic [7:0] mn, input logic [7:0] s);
        chk({name, " min"}, minutes, mn);
        chk({name, " sec"}, seconds, s);
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    logic saw_ht;

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0; sec_tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;

        //              rst tick mode inc  sec    min   ht  mode   blink
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1);
        tbl[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2'b01, 1'b1);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, 2'b01, 1'b1);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 2'b01, 1'b1);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 2'b01, 1'b1);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h03, 1'b0, 2'b01, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 1'b0, 2'b10, 1'b1);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h03, 1'b0, 2'b10, 1'b1);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h03, 1'b0, 2'b10, 1'b1);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h03, 1'b0, 2'b10, 1'b1);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 8'h03, 1'b0, 2'b00, 1'b1);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h03, 8'h03, 1'b0, 2'b00, 1'b1);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 8'h03, 1'b0, 2'b00, 1'b1);
        tbl[13] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 2'b01, 1'b1);
        tbl[14] = mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 8'h03, 1'b0, 2'b10, 1'b1);
        tbl[15] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 2'b00, 1'b1);
        tbl[16] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 8'h03, 1'b0, 2'b01, 1'b1);
        tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 8'h04, 1'b0, 2'b01, 1'b1);
        tbl[18] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1);
        tbl[19] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 2'b00, 1'b1);

        for (int v = 0; v < c_nvec; v++) begin
            cyc(tbl[v].rst_n, tbl[v].tick, tbl[v].mode, tbl[v].inc);
            n_vec++;
            if ({seconds, minutes, hour_tick, set_mode, blink} !==
                {tbl[v].e_sec, tbl[v].e_min, tbl[v].e_ht, tbl[v].e_mode, tbl[v].e_blink}) begin
                n_bad++;
                $display("FAIL vec%0d: got sec=%h min=%h ht=%b mode=%b blink=%b expected sec=%h min=%h ht=%b mode=%b blink=%b",
                         v, seconds, minutes, hour_tick, set_mode, blink,
                         tbl[v].e_sec, tbl[v].e_min, tbl[v].e_ht, tbl[v].e_mode, tbl[v].e_blink);
            end
        end

        // Reset for two cycles, then 61 seconds.
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_time("reset", 8'h00, 8'h00);
        chk("reset mode", {6'd0, set_mode}, 8'h00);
        chk("reset blink", {7'd0, blink}, 8'h01);
        saw_ht = 1'b0;
        for (int k = 0; k < 61; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            saw_ht |= hour_tick;
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            saw_ht |= hour_tick;
        end
        chk_time("count61", 8'h01, 8'h01);
        chk("count61 no hour_tick", {7'd0, saw_ht}, 8'h00);

        // Set 59:58 from 01:01, then two ticks across the hour.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        incs(58);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        incs(57);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_time("set 59:58", 8'h59, 8'h58);
        chk("set 59:58 mode", {6'd0, set_mode}, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk_time("tick 59:59", 8'h59, 8'h59);
        chk("tick 59:59 ht", {7'd0, hour_tick}, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk_time("wrap 00:00", 8'h00, 8'h00);
        chk("wrap ht", {7'd0, hour_tick}, 8'h01);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap ht+1", {7'd0, hour_tick}, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap ht+2", {7'd0, hour_tick}, 8'h00);

        // Set 59:59, then tick together with mode_btn.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        incs(59);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        incs(59);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_time("set 59:59", 8'h59, 8'h59);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk_time("tick+mode", 8'h00, 8'h00);
        chk("tick+mode ht", {7'd0, hour_tick}, 8'h01);
        chk("tick+mode mode", {6'd0, set_mode}, 8'h01);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("tick+mode ht+1", {7'd0, hour_tick}, 8'h00);

        // Minutes wrap inside SET_MIN: no carry, no hour tick.
        incs(59);
        chk_time("setmin 59", 8'h59, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk_time("setmin wrap", 8'h00, 8'h00);
        chk("setmin wrap ht", {7'd0, hour_tick}, 8'h00);
        chk("setmin wrap mode", {6'd0, set_mode}, 8'h01);

        // Blink period with BLINK_DIV=4 after entering SET_SEC.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("blink k0", {7'd0, blink}, 8'h01);
        for (int k = 1; k < 12; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk($sformatf("blink k%0d", k), {7'd0, blink}, {7'd0, ((k / 4) % 2) == 0});
        end

        // Reset while editing.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("edit sec", seconds, 8'h01);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk_time("mid reset", 8'h00, 8'h00);
        chk("mid reset mode", {6'd0, set_mode}, 8'h00);
        chk("mid reset blink", {7'd0, blink}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
